// File: rtl/matrix_loader_if.sv
// Byte stream in from the UART receiver, committed operand pair and status out to the multiplier.
// The loader takes the slave side and the producer/consumer takes the master side.
interface matrix_loader_if #(
    parameter int unsigned DIM = 4,
    parameter int unsigned DW  = 8
);
    logic [DW-1:0]                      rx_data;
    logic                               rx_valid;
    logic [0:DIM-1][0:DIM-1][DW-1:0]    matrix_a;
    logic [0:DIM-1][0:DIM-1][DW-1:0]    matrix_b;
    logic                               start;
    logic                               busy;
    logic                               frame_err;
    logic [2:0]                         state_dbg;

    modport master (
        output rx_data,
        output rx_valid,
        input  matrix_a,
        input  matrix_b,
        input  start,
        input  busy,
        input  frame_err,
        input  state_dbg
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output matrix_a,
        output matrix_b,
        output start,
        output busy,
        output frame_err,
        output state_dbg
    );
endinterface

// File: rtl/matrix_loader.sv
// Frame parser: SYNC, DIM*DIM bytes of A, DIM*DIM bytes of B, XOR checksum.
// Shadow buffers fill during the frame and are committed to the outputs only on a good checksum.
module matrix_loader #(
    parameter int unsigned   DIM            = 4,
    parameter int unsigned   DW             = 8,
    parameter logic [DW-1:0] SYNC_BYTE      = 8'hA5,
    parameter int unsigned   TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            reset,
    matrix_loader_if.slave  bus
);

    localparam int unsigned RowW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RowW-1:0] LastPos = RowW'(DIM - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StCheck = 3'd3
    } state_e;

    typedef logic [0:DIM-1][0:DIM-1][DW-1:0] matrix_t;

    state_e         state_q, state_d;
    logic [RowW-1:0] row_q, row_d;
    logic [RowW-1:0] col_q, col_d;
    logic [DW-1:0]  xor_q, xor_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic           err_q, err_d;
    logic           start_q, start_d;
    matrix_t        shadow_a_q, shadow_a_d;
    matrix_t        shadow_b_q, shadow_b_d;
    matrix_t        mat_a_q, mat_a_d;
    matrix_t        mat_b_q, mat_b_d;

    logic           last_elem;
    logic           byte_ok;

    assign last_elem = (row_q == LastPos) && (col_q == LastPos);
    assign byte_ok   = (bus.rx_data == xor_q);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        xor_d      = xor_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        start_d    = 1'b0;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = StLoadA;
                    row_d   = '0;
                    col_d   = '0;
                    xor_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLoadA, StLoadB: begin
                if (bus.rx_valid) begin
                    if (state_q == StLoadA) begin
                        shadow_a_d[row_q][col_q] = bus.rx_data;
                    end else begin
                        shadow_b_d[row_q][col_q] = bus.rx_data;
                    end
                    xor_d = xor_q ^ bus.rx_data;
                    if (last_elem) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (state_q == StLoadA) ? StLoadB : StCheck;
                    end else if (col_q == LastPos) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StCheck: begin
                if (bus.rx_valid) begin
                    if (byte_ok) begin
                        mat_a_d = shadow_a_q;
                        mat_b_d = shadow_b_q;
                        start_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An arriving byte always beats the terminal timeout cycle.
        if (state_q != StIdle) begin
            if (bus.rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TmoLast) begin
                tmo_d   = '0;
                row_d   = '0;
                col_d   = '0;
                err_d   = 1'b1;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            xor_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            xor_q      <= xor_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            start_q    <= start_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
        end
    end

    assign bus.matrix_a  = mat_a_q;
    assign bus.matrix_b  = mat_b_q;
    assign bus.start     = start_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frame_err = err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: valid, bad-checksum, timeout, reset, filtering, back-to-back.
module tb_matrix_loader;

    localparam int unsigned DIM = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned T   = 40;
    localparam int unsigned N   = DIM * DIM;

    typedef logic [0:DIM-1][0:DIM-1][DW-1:0] matrix_t;

    logic clk;
    logic reset;

    matrix_loader_if #(.DIM(DIM), .DW(DW)) bus ();

    matrix_loader #(
        .DIM(DIM),
        .DW(DW),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    int pulses = 0;

    logic [7:0] fa [N];
    logic [7:0] fb [N];
    matrix_t exp_a, exp_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.start === 1'b1) pulses = pulses + 1;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_body(input logic [7:0] ck);
        for (int i = 0; i < N; i++) send_byte(fa[i]);
        for (int i = 0; i < N; i++) send_byte(fb[i]);
        send_byte(ck);
    endtask

    task automatic send_frame(input logic [7:0] ck);
        send_byte(8'hA5);
        send_body(ck);
    endtask

    task automatic mk_exp();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                exp_a[r][c] = fa[r*DIM+c];
                exp_b[r][c] = fb[r*DIM+c];
            end
    endtask

    // A = identity, B = identity with B[0][1] = 20; checksum 8'h14
    task automatic load_f1();
        for (int i = 0; i < N; i++) begin
            fa[i] = (i % (DIM + 1) == 0) ? 8'd1 : 8'd0;
            fb[i] = fa[i];
        end
        fb[1] = 8'd20;
    endtask

    // A[r][c] = 4r+c, B = 0 except B[3][3] = 5A; checksum 8'h5A
    task automatic load_f2();
        for (int i = 0; i < N; i++) begin
            fa[i] = 8'(i);
            fb[i] = 8'h00;
        end
        fb[N-1] = 8'h5A;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        idle(2);
        total++; if (bus.state_dbg !== 3'd0) begin bad++;
            $display("FAIL reset_state got=%0d want=0", bus.state_dbg); end
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.start !== 1'b0) begin bad++;
            $display("FAIL reset_start got=%b want=0", bus.start); end
        total++; if (bus.frame_err !== 1'b0) begin bad++;
            $display("FAIL reset_err got=%b want=0", bus.frame_err); end
        total++; if (bus.matrix_a !== '0 || bus.matrix_b !== '0) begin bad++;
            $display("FAIL reset_mats got a=%h b=%h want 0", bus.matrix_a, bus.matrix_b); end
        reset = 1'b1;
        idle(2);
        total++; if (bus.busy !== 1'b0) begin bad++;
            $display("FAIL post_reset_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_valid_frame();
        int p0;
        load_f1();
        mk_exp();
        p0 = pulses;
        send_byte(8'hA5);
        total++; if (bus.state_dbg !== 3'd1 || bus.busy !== 1'b1) begin bad++;
            $display("FAIL vf_load_a got=%0d/%b want=1/1", bus.state_dbg, bus.busy); end
        for (int i = 0; i < N; i++) send_byte(fa[i]);
        total++; if (bus.state_dbg !== 3'd2) begin bad++;
            $display("FAIL vf_load_b got=%0d want=2", bus.state_dbg); end
        for (int i = 0; i < N; i++) send_byte(fb[i]);
        total++; if (bus.state_dbg !== 3'd3) begin bad++;
            $display("FAIL vf_check got=%0d want=3", bus.state_dbg); end
        total++; if (bus.matrix_a !== '0) begin bad++;
            $display("FAIL vf_no_early_commit got=%h want=0", bus.matrix_a); end
        send_byte(8'h14);
        total++; if (bus.start !== 1'b1) begin bad++;
            $display("FAIL vf_start got=%b want=1", bus.start); end
        total++; if (bus.matrix_b[0][1] !== 8'd20) begin bad++;
            $display("FAIL vf_b01 got=%0d want=20", bus.matrix_b[0][1]); end
        total++; if (bus.matrix_a !== exp_a) begin bad++;
            $display("FAIL vf_mat_a got=%h want=%h", bus.matrix_a, exp_a); end
        total++; if (bus.matrix_b !== exp_b) begin bad++;
            $display("FAIL vf_mat_b got=%h want=%h", bus.matrix_b, exp_b); end
        total++; if (bus.frame_err !== 1'b0 || bus.state_dbg !== 3'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL vf_status got err=%b st=%0d busy=%b want 0/0/0",
                            bus.frame_err, bus.state_dbg, bus.busy); end
        idle(1);
        total++; if (bus.start !== 1'b0) begin bad++;
            $display("FAIL vf_start_width got=%b want=0", bus.start); end
        idle(2);
        total++; if (pulses - p0 !== 1) begin bad++;
            $display("FAIL vf_pulses got=%0d want=1", pulses - p0); end
    endtask

    task automatic test_bad_checksum();
        int p0;
        load_f1();
        mk_exp();
        p0 = pulses;
        // Perturb the shadow contents so a wrong commit would be visible.
        fa[2] = 8'h77;
        send_frame(8'h15);
        total++; if (bus.frame_err !== 1'b1) begin bad++;
            $display("FAIL bc_err got=%b want=1", bus.frame_err); end
        total++; if (bus.start !== 1'b0 || bus.state_dbg !== 3'd0) begin bad++;
            $display("FAIL bc_start_state got=%b/%0d want=0/0", bus.start, bus.state_dbg); end
        total++; if (bus.matrix_a !== exp_a || bus.matrix_b !== exp_b) begin bad++;
            $display("FAIL bc_mats_kept got a=%h b=%h", bus.matrix_a, bus.matrix_b); end
        idle(3);
        total++; if (pulses - p0 !== 0) begin bad++;
            $display("FAIL bc_pulses got=%0d want=0", pulses - p0); end
    endtask

    task automatic test_timeout();
        load_f1();
        mk_exp();
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(8'h33);
        idle(T - 2);
        total++; if (bus.busy !== 1'b1) begin bad++;
            $display("FAIL to_early got busy=%b want=1", bus.busy); end
        idle(3);
        total++; if (bus.busy !== 1'b0 || bus.frame_err !== 1'b1 || bus.state_dbg !== 3'd0) begin
            bad++; $display("FAIL to_expired got busy=%b err=%b st=%0d want 0/1/0",
                            bus.busy, bus.frame_err, bus.state_dbg); end
        total++; if (bus.matrix_a !== exp_a || bus.matrix_b !== exp_b || bus.start !== 1'b0) begin
            bad++; $display("FAIL to_outputs_kept got a=%h b=%h", bus.matrix_a, bus.matrix_b); end
        load_f2();
        mk_exp();
        send_byte(8'hA5);
        total++; if (bus.frame_err !== 1'b0) begin bad++;
            $display("FAIL to_err_clear got=%b want=0", bus.frame_err); end
        send_body(8'h5A);
        total++; if (bus.start !== 1'b1 || bus.matrix_a !== exp_a || bus.matrix_b !== exp_b) begin
            bad++; $display("FAIL to_recover got start=%b a=%h b=%h", bus.start, bus.matrix_a,
                            bus.matrix_b); end
    endtask

    task automatic test_timeout_boundary();
        load_f1();
        mk_exp();
        send_byte(8'hA5);
        idle(T - 1);
        send_body(8'h14);
        total++; if (bus.start !== 1'b1 || bus.frame_err !== 1'b0) begin bad++;
            $display("FAIL tb_byte_wins got start=%b err=%b want 1/0", bus.start, bus.frame_err); end
        total++; if (bus.matrix_a !== exp_a || bus.matrix_b !== exp_b) begin bad++;
            $display("FAIL tb_mats got a=%h b=%h", bus.matrix_a, bus.matrix_b); end
    endtask

    task automatic test_reset_mid_frame();
        load_f2();
        mk_exp();
        send_byte(8'hA5);
        for (int i = 0; i < 20; i++) send_byte((i < N) ? fa[i] : fb[i-N]);
        #3;
        reset = 1'b0;
        #1;
        total++; if (bus.state_dbg !== 3'd0 || bus.busy !== 1'b0 || bus.start !== 1'b0 ||
                     bus.frame_err !== 1'b0) begin
            bad++; $display("FAIL rm_status got st=%0d busy=%b start=%b err=%b want 0",
                            bus.state_dbg, bus.busy, bus.start, bus.frame_err); end
        total++; if (bus.matrix_a !== '0 || bus.matrix_b !== '0) begin bad++;
            $display("FAIL rm_mats got a=%h b=%h want 0", bus.matrix_a, bus.matrix_b); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        send_frame(8'h5A);
        total++; if (bus.start !== 1'b1 || bus.matrix_a !== exp_a || bus.matrix_b !== exp_b) begin
            bad++; $display("FAIL rm_recover got start=%b a=%h b=%h", bus.start, bus.matrix_a,
                            bus.matrix_b); end
    endtask

    task automatic test_idle_filter();
        send_byte(8'h00);
        send_byte(8'hFF);
        total++; if (bus.state_dbg !== 3'd0 || bus.busy !== 1'b0) begin bad++;
            $display("FAIL if_ignored got st=%0d busy=%b want 0/0", bus.state_dbg, bus.busy); end
        load_f1();
        fb[1] = 8'h00;
        fa[5] = 8'hA5;
        mk_exp();
        send_frame(8'hA4);
        total++; if (bus.start !== 1'b1 || bus.frame_err !== 1'b0) begin bad++;
            $display("FAIL if_commit got start=%b err=%b want 1/0", bus.start, bus.frame_err); end
        total++; if (bus.matrix_a[1][1] !== 8'hA5) begin bad++;
            $display("FAIL if_a11 got=%h want=a5", bus.matrix_a[1][1]); end
        total++; if (bus.matrix_a !== exp_a || bus.matrix_b !== exp_b) begin bad++;
            $display("FAIL if_mats got a=%h b=%h", bus.matrix_a, bus.matrix_b); end
    endtask

    task automatic test_back_to_back();
        int p0;
        idle(2);
        p0 = pulses;
        load_f1();
        mk_exp();
        send_frame(8'h14);
        total++; if (bus.start !== 1'b1 || bus.matrix_a !== exp_a || bus.matrix_b !== exp_b) begin
            bad++; $display("FAIL bb_first got start=%b a=%h b=%h", bus.start, bus.matrix_a,
                            bus.matrix_b); end
        load_f2();
        mk_exp();
        send_frame(8'h5A);
        total++; if (bus.start !== 1'b1 || bus.matrix_a !== exp_a || bus.matrix_b !== exp_b) begin
            bad++; $display("FAIL bb_second got start=%b a=%h b=%h", bus.start, bus.matrix_a,
                            bus.matrix_b); end
        idle(1);
        total++; if (bus.start !== 1'b0) begin bad++;
            $display("FAIL bb_start_drop got=%b want=0", bus.start); end
        idle(2);
        total++; if (pulses - p0 !== 2) begin bad++;
            $display("FAIL bb_pulses got=%0d want=2", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_frame();
        test_idle_filter();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
